rle_crc_encoder: RTL and testbench

Byte-serial run-length encoder with CRC32 generation: the compress-side counterpart of the decompressor's RLE-expand and CRC32-integrity stages. It consumes raw block bytes with a valid/ready handshake and emits `{run_length-1, byte}` tokens. It also produces the standard reflected CRC32 of the raw block, so the decompressor's CRC output can be checked against it end to end. It sits upstream of the Huffman stage in the compression path.

---
 rtl/comp_pkg.sv | 30 +++
 rtl/crc32_byte_engine.sv | 25 ++
 rtl/rle_crc_encoder.sv | 133 +++++++++++++
 tb/tb_rle_crc_encoder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared compression-path types and the reflected CRC32 byte step used by
// both the encoder and the decompressor checker.
package comp_pkg;

  localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [7:0] len_m1;
    logic [7:0] sym;
  } rle_tok_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_CRC
  } enc_state_e;

  // LSB-first, one byte per call; the caller owns seeding and final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_byte_engine.sv
// CRC32 register: seeds on init, folds in one byte per accepted cycle.
module crc32_byte_engine
  import comp_pkg::*;
#(
  parameter logic [31:0] CRC_INIT = CRC32_INIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  logic        init,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (accept) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/rle_crc_encoder.sv
// Run-length encoder emitting {len-1, byte} tokens plus the CRC32 of the raw block.
// state    | meaning
// ST_IDLE  | no run held
// ST_RUN   | run held in cur_byte / cur_cnt
// ST_FLUSH | final run pending after raw_last
// ST_CRC   | wait for last-token handshake, then pulse crc32_valid
module rle_crc_encoder
  import comp_pkg::*;
#(
  parameter int          RUN_W    = 8,
  parameter logic [31:0] CRC_INIT = CRC32_INIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         raw_data_in,
  input  logic               raw_valid,
  input  logic               raw_last,
  output logic               raw_ready,
  output logic [RUN_W+7:0]   tok_data,
  output logic               tok_valid,
  output logic               tok_last,
  input  logic               tok_ready,
  output logic [31:0]        crc32_out,
  output logic               crc32_valid
);

  enc_state_e       state, state_n;
  logic [7:0]       cur_byte;
  logic [RUN_W-1:0] cur_cnt;
  logic [31:0]      crc_reg;
  logic             tok_free, accept, extend;
  logic             load_tok, load_last, load_cur, inc_cnt, crc_init;

  assign tok_free  = !tok_valid || tok_ready;
  // Gated by rst_n so the handshake is closed while reset is held.
  assign raw_ready = rst_n && (state == ST_IDLE || state == ST_RUN) && tok_free;
  assign accept    = raw_ready && raw_valid;
  assign extend    = (raw_data_in == cur_byte) && (cur_cnt != '1);

  always_comb begin
    state_n   = state;
    load_tok  = 1'b0;
    load_last = 1'b0;
    load_cur  = 1'b0;
    inc_cnt   = 1'b0;
    crc_init  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load_cur = 1'b1;
          state_n  = raw_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (extend) begin
            inc_cnt = 1'b1;
          end else begin
            load_tok = 1'b1;
            load_cur = 1'b1;
          end
          if (raw_last) state_n = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (tok_free) begin
          load_tok  = 1'b1;
          load_last = 1'b1;
          state_n   = ST_CRC;
        end
      end
      ST_CRC: begin
        if (tok_valid && tok_ready) begin
          crc_init = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_byte <= '0;
      cur_cnt  <= '0;
    end else begin
      state <= state_n;
      if (load_cur) begin
        cur_byte <= raw_data_in;
        cur_cnt  <= '0;
      end else if (inc_cnt) begin
        cur_cnt <= cur_cnt + RUN_W'(1);
      end
    end
  end

  // A load may coincide with the handshake of the previous token: no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_data  <= '0;
      tok_valid <= 1'b0;
      tok_last  <= 1'b0;
    end else if (load_tok) begin
      tok_data  <= {cur_cnt, cur_byte};
      tok_valid <= 1'b1;
      tok_last  <= load_last;
    end else if (tok_ready) begin
      tok_valid <= 1'b0;
      tok_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc32_out   <= '0;
      crc32_valid <= 1'b0;
    end else begin
      crc32_valid <= crc_init;
      if (crc_init) crc32_out <= ~crc_reg;
    end
  end

  crc32_byte_engine #(.CRC_INIT(CRC_INIT)) u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (accept),
    .init   (crc_init),
    .data   (raw_data_in),
    .crc    (crc_reg)
  );

endmodule

// File: tb/tb_rle_crc_encoder.sv
// Scoreboard bench for rle_crc_encoder: a reference RLE/CRC model fills the
// expected-token queue, the monitor pops it on every token handshake.
module tb_rle_crc_encoder;

  localparam int RUN_W = 8;
  localparam int TOK_W = RUN_W + 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        raw_data_in = '0;
  logic              raw_valid = 1'b0;
  logic              raw_last = 1'b0;
  logic              raw_ready;
  logic [RUN_W+7:0]  tok_data;
  logic              tok_valid;
  logic              tok_last;
  logic              tok_ready = 1'b1;
  logic [31:0]       crc32_out;
  logic              crc32_valid;

  int checks = 0;
  int errors = 0;

  logic [TOK_W-1:0] exp_q[$];
  logic [7:0]       blk[$];
  logic [31:0]      exp_crc;
  bit               last_acc;

  rle_crc_encoder #(.RUN_W(RUN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_data_in (raw_data_in),
    .raw_valid   (raw_valid),
    .raw_last    (raw_last),
    .raw_ready   (raw_ready),
    .tok_data    (tok_data),
    .tok_valid   (tok_valid),
    .tok_last    (tok_last),
    .tok_ready   (tok_ready),
    .crc32_out   (crc32_out),
    .crc32_valid (crc32_valid)
  );

  always #5 clk = ~clk;

  // Reference model: plain bitwise reflected CRC32 and greedy RLE capped at 256.
  function automatic logic [31:0] model_crc();
    logic [31:0] c;
    bit fb;
    c = 32'hFFFF_FFFF;
    foreach (blk[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ blk[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic model_rle();
    int cnt;
    logic [7:0] cur;
    cur = blk[0];
    cnt = 0;
    for (int i = 1; i < blk.size(); i++) begin
      if (blk[i] == cur && cnt < 255) begin
        cnt++;
      end else begin
        exp_q.push_back({1'b0, cnt[7:0], cur});
        cur = blk[i];
        cnt = 0;
      end
    end
    exp_q.push_back({1'b1, cnt[7:0], cur});
  endtask

  // Drives blk through the encoder while a monitor scores tokens and the CRC.
  task automatic run_block(input bit rand_ready, output logic [31:0] crc_seen);
    int crc_pulses;
    exp_q.delete();
    model_rle();
    exp_crc    = model_crc();
    last_acc   = 1'b0;
    crc_pulses = 0;
    crc_seen   = '0;
    fork
      begin : driver
        int wait_cyc;
        bit abort;
        abort = 1'b0;
        for (int i = 0; i < blk.size() && !abort; i++) begin
          @(negedge clk);
          raw_valid   = 1'b1;
          raw_data_in = blk[i];
          raw_last    = (i == blk.size() - 1);
          #4;
          wait_cyc = 0;
          while (!raw_ready && !abort) begin
            @(negedge clk);
            #4;
            wait_cyc++;
            if (wait_cyc > 200) begin
              errors++;
              $display("FAIL raw_ready_timeout byte %0d: raw_ready=%b required 1 within 200 cycles", i, raw_ready);
              abort = 1'b1;
            end
          end
          if (!abort) @(posedge clk);
        end
        if (!abort) last_acc = 1'b1;
        @(negedge clk);
        raw_valid = 1'b0;
        raw_last  = 1'b0;
      end
      begin : monitor
        int cyc, stall_left;
        bit done, prev_stall;
        logic [TOK_W-1:0] prev_tok, e;
        cyc = 0; stall_left = 0; done = 1'b0; prev_stall = 1'b0; prev_tok = '0;
        while (!done) begin
          @(negedge clk);
          cyc++;
          if (prev_stall) begin
            checks++;
            if (tok_valid !== 1'b1 || {tok_last, tok_data} !== prev_tok) begin
              errors++;
              $display("FAIL stall_hold: valid=%b tok=%h required valid=1 tok=%h", tok_valid, {tok_last, tok_data}, prev_tok);
            end
          end
          if (crc32_valid) begin
            crc_pulses++;
            crc_seen = crc32_out;
          end else if (crc_pulses > 0) begin
            done = 1'b1;
          end else if (last_acc) begin
            checks++;
            if (raw_ready !== 1'b0) begin
              errors++;
              $display("FAIL ready_in_flush: raw_ready=%b required 0", raw_ready);
            end
          end
          if (rand_ready) begin
            if (stall_left > 0) begin
              tok_ready = 1'b0;
              stall_left--;
            end else if ($urandom_range(0, 3) == 0) begin
              tok_ready  = 1'b0;
              stall_left = $urandom_range(1, 10) - 1;
            end else begin
              tok_ready = 1'b1;
            end
          end else begin
            tok_ready = 1'b1;
          end
          if (tok_valid && tok_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL extra_token: got %h required none", {tok_last, tok_data});
            end else begin
              e = exp_q.pop_front();
              if ({tok_last, tok_data} !== e) begin
                errors++;
                $display("FAIL token: got last=%b len_m1=%0d sym=%h required last=%b len_m1=%0d sym=%h",
                         tok_last, tok_data[15:8], tok_data[7:0], e[16], e[15:8], e[7:0]);
              end
            end
          end
          prev_stall = tok_valid && !tok_ready;
          prev_tok   = {tok_last, tok_data};
          if (cyc > 20000) begin
            errors++;
            $display("FAIL block_timeout: crc pulses=%0d required 1 within 20000 cycles", crc_pulses);
            done = 1'b1;
          end
        end
      end
    join
    tok_ready = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_tokens: %0d left required 0", exp_q.size());
    end
    checks++;
    if (crc_pulses != 1) begin
      errors++;
      $display("FAIL crc_pulse_width: got %0d cycles required 1", crc_pulses);
    end
    checks++;
    if (crc_seen !== exp_crc) begin
      errors++;
      $display("FAIL crc_model: got %h required %h", crc_seen, exp_crc);
    end
  endtask

  task automatic load_ascii();
    blk.delete();
    for (int i = 0; i < 9; i++) blk.push_back(8'h31 + 8'(i));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    checks++;
    if ({raw_ready, tok_valid, tok_last, crc32_valid} !== 4'b0 || tok_data !== '0 || crc32_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b tv=%b tl=%b cv=%b td=%h crc=%h required all 0",
               raw_ready, tok_valid, tok_last, crc32_valid, tok_data, crc32_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (raw_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 1", raw_ready);
    end
  endtask

  task automatic test_ascii();
    logic [31:0] c;
    load_ascii();
    run_block(1'b0, c);
    checks++;
    if (c !== 32'hCBF4_3926) begin
      errors++;
      $display("FAIL ascii_crc: got %h required cbf43926", c);
    end
  endtask

  task automatic test_short_run();
    logic [31:0] c;
    blk.delete();
    repeat (5) blk.push_back(8'h41);
    blk.push_back(8'h42);
    run_block(1'b0, c);
  endtask

  task automatic test_max_run();
    logic [31:0] c;
    blk.delete();
    repeat (300) blk.push_back(8'h00);
    run_block(1'b0, c);
  endtask

  task automatic test_single();
    logic [31:0] c;
    blk.delete();
    blk.push_back(8'hFF);
    run_block(1'b0, c);
    checks++;
    if (c !== 32'hFF00_0000) begin
      errors++;
      $display("FAIL single_crc: got %h required ff000000", c);
    end
  endtask

  task automatic test_random_stall();
    logic [31:0] c;
    logic [7:0] b;
    blk.delete();
    b = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 3));
      blk.push_back(b);
    end
    run_block(1'b1, c);
  endtask

  task automatic test_back_to_back();
    logic [31:0] c;
    blk.delete();
    for (int i = 0; i < 40; i++) blk.push_back(8'($urandom_range(0, 1)));
    run_block(1'b0, c);
    blk.delete();
    for (int i = 0; i < 20; i++) blk.push_back(8'hA0 + 8'(i / 3));
    run_block(1'b1, c);
  endtask

  task automatic test_mid_reset();
    logic [31:0] c;
    tok_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      raw_valid   = 1'b1;
      raw_data_in = 8'h11 * 8'(i + 1);
      raw_last    = 1'b0;
    end
    @(negedge clk);
    raw_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({raw_ready, tok_valid, tok_last, crc32_valid} !== 4'b0 || tok_data !== '0 || crc32_out !== '0) begin
      errors++;
      $display("FAIL async_reset: ready=%b tv=%b tl=%b cv=%b td=%h crc=%h required all 0",
               raw_ready, tok_valid, tok_last, crc32_valid, tok_data, crc32_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_ascii();
    run_block(1'b0, c);
    checks++;
    if (c !== 32'hCBF4_3926) begin
      errors++;
      $display("FAIL crc_after_reset: got %h required cbf43926", c);
    end
  endtask

  initial begin
    test_reset();
    test_ascii();
    test_short_run();
    test_max_run();
    test_single();
    test_random_stall();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
